vga_pattern_gen: RTL and testbench

Upstream pixel source for the VGA_Controller display timing block. It consumes the controller's current pixel coordinates (oCurrent_X/oCurrent_Y) and returns 10-bit R/G/B, which are wired to iRed/iGreen/iBlue. It generates one of four test patterns:
- colour bars
- checkerboard
- gradient
- bouncing box, animated once per frame

It detects frame boundaries and applies pattern changes only at a frame boundary, so no frame is ever torn.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_box_mover.sv | 68 ++++++
 rtl/vga_pattern_gen.sv | 128 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern generator and its box animator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_CHECK = 2'd1,
        PAT_GRAD  = 2'd2,
        PAT_BOX   = 2'd3
    } pattern_e;

    localparam logic [9:0] C_FULL = 10'h3FF;
    localparam logic [9:0] C_ZERO = 10'h000;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } rgb_t;

    // One animation axis: position plus direction (dec=1 means moving toward 0).
    typedef struct packed {
        logic [10:0] pos;
        logic        dec;
    } axis_t;

    // Bar order white, yellow, cyan, green, magenta, red, blue, black:
    // each channel is a single inverted bit of the bar index.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        c.r = idx[1] ? C_ZERO : C_FULL;
        c.g = idx[2] ? C_ZERO : C_FULL;
        c.b = idx[0] ? C_ZERO : C_FULL;
        return c;
    endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state; advances one step per frame tick and reflects at the edges.
module vga_box_mover
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int BOX_SIZE = 32,
    parameter int BOX_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [9:0] box_x_nxt,
    output logic [9:0] box_y_nxt
);

    localparam logic [10:0] X_LIM = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_LIM = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP  = 11'(BOX_STEP);

    axis_t x_q, x_d, x_step;
    axis_t y_q, y_d, y_step;

    // 11-bit arithmetic keeps pos+STEP from wrapping before the limit compare.
    function automatic axis_t step_axis(input axis_t cur, input logic [10:0] lim);
        axis_t nxt;
        nxt = cur;
        if (!cur.dec) begin
            if (cur.pos + STEP >= lim) begin
                nxt.pos = lim;
                nxt.dec = 1'b1;
            end else begin
                nxt.pos = cur.pos + STEP;
            end
        end else if (cur.pos <= STEP) begin
            nxt.pos = '0;
            nxt.dec = 1'b0;
        end else begin
            nxt.pos = cur.pos - STEP;
        end
        return nxt;
    endfunction

    always_comb begin
        x_step = step_axis(x_q, X_LIM);
        y_step = step_axis(y_q, Y_LIM);
        x_d    = frame_tick ? x_step : x_q;
        y_d    = frame_tick ? y_step : y_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign box_x     = x_q.pos[9:0];
    assign box_y     = y_q.pos[9:0];
    assign box_x_nxt = x_step.pos[9:0];
    assign box_y_nxt = y_step.pos[9:0];

endmodule

// File: rtl/vga_pattern_gen.sv
// Test-pattern pixel source for the VGA timing controller; pattern and box position
// change only on a detected frame wrap so a frame is never rendered half-and-half.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int         H_ACTIVE = H_ACTIVE_DEF,
    parameter int         V_ACTIVE = V_ACTIVE_DEF,
    parameter int         BOX_SIZE = 32,
    parameter int         BOX_STEP = 4,
    parameter logic [9:0] BG_BLUE  = 10'h100
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [9:0] iCurrent_X,
    input  logic [9:0] iCurrent_Y,
    input  logic [1:0] iPattern_Sel,
    output logic [9:0] oRed,
    output logic [9:0] oGreen,
    output logic [9:0] oBlue,
    output logic       oFrame_Tick,
    output logic [7:0] oFrame_Count
);

    localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
    localparam logic [10:0] V_LIM = 11'(V_ACTIVE);
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);
    localparam logic [10:0] SIZE  = 11'(BOX_SIZE);

    logic [9:0] prev_y_q, prev_y_d;
    pattern_e   pat_q, pat_d;
    logic       tick_q, tick_d;
    logic [7:0] cnt_q, cnt_d;
    rgb_t       rgb_q, rgb_d;

    logic        frame_tick;
    logic [10:0] x_w, y_w;
    logic [9:0]  box_x, box_y, box_x_nxt, box_y_nxt;
    logic [10:0] bx, by;
    logic [2:0]  bar_idx;
    logic        active, in_box;

    vga_box_mover #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .BOX_SIZE (BOX_SIZE),
        .BOX_STEP (BOX_STEP)
    ) u_box (
        .clk        (iCLK),
        .rst        (iRST),
        .frame_tick (frame_tick),
        .box_x      (box_x),
        .box_y      (box_y),
        .box_x_nxt  (box_x_nxt),
        .box_y_nxt  (box_y_nxt)
    );

    assign x_w = {1'b0, iCurrent_X};
    assign y_w = {1'b0, iCurrent_Y};

    // Frame wrap: the row number moved backwards since last cycle.
    always_comb begin
        frame_tick = iCurrent_Y < prev_y_q;
        prev_y_d   = iCurrent_Y;
        tick_d     = frame_tick;
        pat_d      = frame_tick ? pattern_e'(iPattern_Sel) : pat_q;
        cnt_d      = cnt_q + {7'd0, frame_tick};
    end

    // Render with next-state pattern/box so the tick cycle already shows the new frame.
    always_comb begin
        bx      = {1'b0, frame_tick ? box_x_nxt : box_x};
        by      = {1'b0, frame_tick ? box_y_nxt : box_y};
        active  = (x_w < H_LIM) && (y_w < V_LIM);
        in_box  = (x_w >= bx) && (x_w < bx + SIZE) && (y_w >= by) && (y_w < by + SIZE);
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (x_w >= BAR_W * 11'(i)) begin
                bar_idx = 3'(i);
            end
        end
        rgb_d = '0;
        if (active) begin
            case (pat_d)
                PAT_BARS: rgb_d = bar_colour(bar_idx);
                PAT_CHECK: begin
                    if ((iCurrent_X[5] ^ iCurrent_Y[5]) == 1'b0) begin
                        rgb_d = '{r: C_FULL, g: C_FULL, b: C_FULL};
                    end
                end
                PAT_GRAD: begin
                    rgb_d.r = iCurrent_X;
                    rgb_d.g = {iCurrent_Y[8:0], 1'b0};
                    rgb_d.b = C_FULL - iCurrent_X;
                end
                default: begin
                    if (in_box) begin
                        rgb_d = '{r: C_FULL, g: C_ZERO, b: C_ZERO};
                    end else begin
                        rgb_d = '{r: C_ZERO, g: C_ZERO, b: BG_BLUE};
                    end
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            prev_y_q <= '0;
            pat_q    <= PAT_BARS;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            rgb_q    <= '0;
        end else begin
            prev_y_q <= prev_y_d;
            pat_q    <= pat_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            rgb_q    <= rgb_d;
        end
    end

    assign oRed         = rgb_q.r;
    assign oGreen       = rgb_q.g;
    assign oBlue        = rgb_q.b;
    assign oFrame_Tick  = tick_q;
    assign oFrame_Count = cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: stimulus pushes model predictions, a monitor checks them.
module tb_vga_pattern_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic [1:0] sel = '0;
    logic [9:0] oRed, oGreen, oBlue;
    logic       oFrame_Tick;
    logic [7:0] oFrame_Count;

    vga_pattern_gen dut (
        .iCLK         (clk),
        .iRST         (rst),
        .iCurrent_X   (x),
        .iCurrent_Y   (y),
        .iPattern_Sel (sel),
        .oRed         (oRed),
        .oGreen       (oGreen),
        .oBlue        (oBlue),
        .oFrame_Tick  (oFrame_Tick),
        .oFrame_Count (oFrame_Count)
    );

    always #5 clk = ~clk;

    localparam int W = 640, H = 480, BOX = 32, STEP = 4;
    localparam int X_MAX = W - BOX, Y_MAX = H - BOX;

    typedef struct {
        int         x, y;
        logic [9:0] r, g, b;
        logic       tick;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain integers.
    int m_prev_y, m_pat, m_cnt, m_bx, m_by, m_dx, m_dy;

    int bar_r[8] = '{1, 1, 0, 0, 1, 1, 0, 0};
    int bar_g[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    int bar_b[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    task automatic chk(input string nm, input logic [29:0] got, input logic [29:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_prev_y = 0; m_pat = 0; m_cnt = 0;
        m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
    endtask

    task automatic move(inout int p, inout int d, input int lim);
        p = p + STEP * d;
        if (p >= lim) begin
            p = lim; d = -1;
        end else if (p <= 0) begin
            p = 0; d = 1;
        end
    endtask

    function automatic exp_t expect_px(input int xi, input int yi);
        exp_t e;
        int r, g, b;
        r = 0; g = 0; b = 0;
        if (xi < W && yi < H) begin
            case (m_pat)
                0: begin
                    r = bar_r[xi / 80] * 1023;
                    g = bar_g[xi / 80] * 1023;
                    b = bar_b[xi / 80] * 1023;
                end
                1: if ((xi / 32) % 2 == (yi / 32) % 2) begin
                    r = 1023; g = 1023; b = 1023;
                end
                2: begin
                    r = xi; g = 2 * yi; b = 1023 - xi;
                end
                default: begin
                    if (xi >= m_bx && xi < m_bx + BOX && yi >= m_by && yi < m_by + BOX) r = 1023;
                    else b = 256;
                end
            endcase
        end
        e.x = xi; e.y = yi;
        e.r = 10'(r); e.g = 10'(g); e.b = 10'(b);
        e.tick = 1'b0; e.cnt = '0;
        return e;
    endfunction

    task automatic drive(input int xi, input int yi, input int si);
        exp_t e;
        bit tk;
        xi = xi & 1023; yi = yi & 1023; si = si & 3;
        @(negedge clk);
        x = 10'(xi); y = 10'(yi); sel = 2'(si);
        tk = (yi < m_prev_y);
        if (tk) begin
            m_pat = si;
            m_cnt = (m_cnt + 1) % 256;
            move(m_bx, m_dx, X_MAX);
            move(m_by, m_dy, Y_MAX);
        end
        m_prev_y = yi;
        e = expect_px(xi, yi);
        e.tick = tk;
        e.cnt  = 8'(m_cnt);
        q.push_back(e);
    endtask

    task automatic drive_box_edges(input int s);
        int bx, by;
        bx = m_bx; by = m_by;
        drive(bx - 1, by, s);
        drive(bx, by, s);
        drive(bx + BOX - 1, by + BOX - 1, s);
        drive(bx + BOX, by + BOX - 1, s);
    endtask

    // Monitor: outputs are always valid, one registered result per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk($sformatf("rgb(%0d,%0d)", e.x, e.y), {oRed, oGreen, oBlue}, {e.r, e.g, e.b});
                chk($sformatf("tick(%0d,%0d)", e.x, e.y), 30'(oFrame_Tick), 30'(e.tick));
                chk($sformatf("count(%0d,%0d)", e.x, e.y), 30'(oFrame_Count), 30'(e.cnt));
            end
        end
    end

    initial begin
        int s;
        model_reset();
        #1 rst = 1'b1;
        #10;
        chk("reset_rgb", {oRed, oGreen, oBlue}, 30'd0);
        chk("reset_tick", 30'(oFrame_Tick), 30'd0);
        chk("reset_count", 30'(oFrame_Count), 30'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 650; i++) drive(i, 0, 0);

        drive(32, 479, 1); drive(32, 0, 1); drive(32, 32, 1); drive(31, 32, 1);

        drive(100, 479, 2); drive(100, 0, 2); drive(100, 200, 2); drive(700, 200, 2);

        drive(4, 479, 3); drive(4, 0, 3); drive_box_edges(0);

        for (int f = 0; f < 350; f++) begin
            s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : 3;
            drive($urandom_range(0, 639), 0, s);
            drive_box_edges($urandom_range(0, 3));
            for (int k = 0; k < 5; k++) begin
                drive($urandom_range(0, 1023), 96 * k + $urandom_range(0, 95), $urandom_range(0, 3));
            end
            drive($urandom_range(0, 1023), $urandom_range(480, 524), $urandom_range(0, 3));
        end

        drive(0, 479, 0); drive(0, 0, 0);
        drive(100, 100, 1); drive(300, 100, 1); drive(300, 479, 1);
        drive(32, 0, 1); drive(32, 32, 1);

        drive(200, 300, 3);
        @(posedge clk);
        #3;
        rst = 1'b1; x = '0; y = '0; sel = '0;
        #1;
        chk("midreset_rgb", {oRed, oGreen, oBlue}, 30'd0);
        chk("midreset_tick", 30'(oFrame_Tick), 30'd0);
        chk("midreset_count", 30'(oFrame_Count), 30'd0);
        repeat (2) @(negedge clk);
        model_reset();
        rst = 1'b0;

        drive_box_edges(3);
        for (int f = 0; f < 257; f++) begin
            drive($urandom_range(0, 639), 479, $urandom_range(0, 3));
            drive($urandom_range(0, 639), 0, 3);
        end
        drive_box_edges(1);

        repeat (4) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
